clock_set_ctrl: RTL and testbench

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

---
 rtl/clock_set_ctrl_if.sv | 29 ++
 rtl/clock_set_ctrl.sv | 172 +++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/clock_set_ctrl_if.sv
// Clock-set controller bus: button/tick inputs and counter-control outputs.
// master drives the inputs, slave is the controller itself.
interface clock_set_ctrl_if;
  logic       i_tick_1hz;
  logic       i_btn_mode;
  logic       i_btn_inc;
  logic       i_sec_ovf;
  logic       i_min_ovf;
  logic       o_sec_en;
  logic       o_min_en;
  logic       o_hour_en;
  logic       o_sec_srst;
  logic [1:0] o_mode;
  logic       o_blink;

  modport master (
    output i_tick_1hz, i_btn_mode, i_btn_inc,
    output i_sec_ovf, i_min_ovf,
    input  o_sec_en, o_min_en, o_hour_en,
    input  o_sec_srst, o_mode, o_blink
  );

  modport slave (
    input  i_tick_1hz, i_btn_mode, i_btn_inc,
    input  i_sec_ovf, i_min_ovf,
    output o_sec_en, o_min_en, o_hour_en,
    output o_sec_srst, o_mode, o_blink
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Clock time-setting controller: RUN / SET_HOUR / SET_MIN with
// button auto-repeat, idle timeout and field blink.
module clock_set_ctrl #(
  parameter int BLINK_CYC     = 25000000,
  parameter int BLINK_W       = 25,
  parameter int HOLD_TICKS    = 2,
  parameter int TIMEOUT_TICKS = 10
) (
  input logic             i_clk,
  input logic             i_rst,
  clock_set_ctrl_if.slave bus
);

  localparam int HW = $clog2(HOLD_TICKS + 2);
  localparam int TW = $clog2(TIMEOUT_TICKS + 2);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_TICKS);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_TICKS - 1);
  localparam logic [BLINK_W-1:0] DIV_LAST = BLINK_W'(BLINK_CYC - 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    BAD      = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic               mode_prev_q, mode_prev_d;
  logic               inc_prev_q, inc_prev_d;
  logic               armed_q, armed_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [TW-1:0]      to_q, to_d;
  logic [BLINK_W-1:0] div_q, div_d;
  logic               blink_q, blink_d;
  logic               sec_en_q, sec_en_d;
  logic               min_en_q, min_en_d;
  logic               hour_en_q, hour_en_d;
  logic               srst_q, srst_d;

  logic mode_rise, inc_rise, btn_edge;
  logic in_set, rpt, activity, to_hit;
  logic state_chg, inc_pulse;

  // edges are ignored on the first cycle after reset
  assign mode_rise = armed_q & bus.i_btn_mode & ~mode_prev_q;
  assign inc_rise  = armed_q & bus.i_btn_inc & ~inc_prev_q;
  assign btn_edge  = armed_q &
                     ((bus.i_btn_mode ^ mode_prev_q) |
                      (bus.i_btn_inc ^ inc_prev_q));
  assign in_set    = (state_q == SET_HOUR) | (state_q == SET_MIN);
  assign rpt       = in_set & bus.i_btn_inc & bus.i_tick_1hz &
                     (hold_q == HOLD_MAX);
  assign activity  = btn_edge | rpt;
  assign to_hit    = in_set & bus.i_tick_1hz & ~activity &
                     (to_q >= TO_LAST);
  assign state_chg = (state_d != state_q);
  assign inc_pulse = in_set & ~state_chg & (inc_rise | rpt);

  // next-state: mode press wins over timeout; 11 recovers to RUN
  always_comb begin
    state_d = state_q;
    srst_d  = 1'b0;
    case (state_q)
      RUN: begin
        if (mode_rise) state_d = SET_HOUR;
      end
      SET_HOUR: begin
        if (mode_rise)   state_d = SET_MIN;
        else if (to_hit) state_d = RUN;
      end
      SET_MIN: begin
        if (mode_rise) begin
          state_d = RUN;
          srst_d  = 1'b1;
        end else if (to_hit) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // counter enables: pass-through in RUN, increments while setting
  always_comb begin
    sec_en_d  = (state_q == RUN) & bus.i_tick_1hz;
    min_en_d  = (state_q == SET_MIN) & inc_pulse;
    hour_en_d = (state_q == SET_HOUR) & inc_pulse;
    if (state_q == RUN) begin
      min_en_d  = bus.i_sec_ovf;
      hour_en_d = bus.i_min_ovf;
    end
  end

  // hold and timeout counters, both saturating
  always_comb begin
    hold_d = hold_q;
    to_d   = to_q;
    if (!bus.i_btn_inc || state_chg)
      hold_d = '0;
    else if (bus.i_tick_1hz && hold_q < HOLD_MAX)
      hold_d = hold_q + 1'b1;
    if (!in_set || state_chg || activity)
      to_d = '0;
    else if (bus.i_tick_1hz && to_q < TO_MAX)
      to_d = to_q + 1'b1;
  end

  // blink divider restarts lit on every state change
  always_comb begin
    div_d   = div_q;
    blink_d = blink_q;
    if (state_chg) begin
      div_d   = '0;
      blink_d = (state_d == SET_HOUR) | (state_d == SET_MIN);
    end else if (!in_set) begin
      div_d   = '0;
      blink_d = 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_d   = '0;
      blink_d = ~blink_q;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  // button history for edge detection
  always_comb begin
    mode_prev_d = bus.i_btn_mode;
    inc_prev_d  = bus.i_btn_inc;
    armed_d     = 1'b1;
  end

  // state and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= RUN;
      mode_prev_q <= 1'b0;
      inc_prev_q  <= 1'b0;
      armed_q     <= 1'b0;
      hold_q      <= '0;
      to_q        <= '0;
      div_q       <= '0;
      blink_q     <= 1'b0;
      sec_en_q    <= 1'b0;
      min_en_q    <= 1'b0;
      hour_en_q   <= 1'b0;
      srst_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_prev_q <= mode_prev_d;
      inc_prev_q  <= inc_prev_d;
      armed_q     <= armed_d;
      hold_q      <= hold_d;
      to_q        <= to_d;
      div_q       <= div_d;
      blink_q     <= blink_d;
      sec_en_q    <= sec_en_d;
      min_en_q    <= min_en_d;
      hour_en_q   <= hour_en_d;
      srst_q      <= srst_d;
    end
  end

  assign bus.o_sec_en   = sec_en_q;
  assign bus.o_min_en   = min_en_q;
  assign bus.o_hour_en  = hour_en_q;
  assign bus.o_sec_srst = srst_q;
  assign bus.o_mode     = state_q;
  assign bus.o_blink    = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: behavioural model checked every cycle
// plus directed scenarios with literal expectations.
module tb_clock_set_ctrl;
  localparam int BLINK = 4;
  localparam int HOLD  = 2;
  localparam int TO    = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  clock_set_ctrl_if bus();

  clock_set_ctrl #(
    .BLINK_CYC(BLINK),
    .BLINK_W(3),
    .HOLD_TICKS(HOLD),
    .TIMEOUT_TICKS(TO)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endfunction

  // model state: mode 0 RUN, 1 SET_HOUR, 2 SET_MIN
  int m_mode, m_hold, m_idle, m_age, nxt;
  bit m_pm, m_pi, m_armed;
  bit mp, ip, any_e, rep, chg;
  int e_sec, e_min, e_hour, e_srst, e_blink;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_mode = 0; m_hold = 0; m_idle = 0; m_age = 0;
      m_pm = 0; m_pi = 0; m_armed = 0;
      e_sec = 0; e_min = 0; e_hour = 0;
      e_srst = 0; e_blink = 0;
    end else begin
      mp = m_armed && bus.i_btn_mode && !m_pm;
      ip = m_armed && bus.i_btn_inc && !m_pi;
      any_e = m_armed && (bus.i_btn_mode != m_pm ||
                          bus.i_btn_inc != m_pi);
      rep = m_mode != 0 && bus.i_btn_inc &&
            bus.i_tick_1hz && m_hold >= HOLD;
      nxt = m_mode;
      if (mp) nxt = (m_mode + 1) % 3;
      else if (m_mode != 0 && bus.i_tick_1hz && !any_e &&
               !rep && m_idle + 1 >= TO) nxt = 0;
      chg = nxt != m_mode;
      e_sec  = int'(m_mode == 0 && bus.i_tick_1hz);
      e_min  = (m_mode == 0) ? int'(bus.i_sec_ovf) :
               int'(m_mode == 2 && !chg && (ip || rep));
      e_hour = (m_mode == 0) ? int'(bus.i_min_ovf) :
               int'(m_mode == 1 && !chg && (ip || rep));
      e_srst = int'(m_mode == 2 && mp);
      if (!bus.i_btn_inc || chg) m_hold = 0;
      else if (bus.i_tick_1hz && m_hold < HOLD) m_hold++;
      if (nxt == 0 || chg || any_e || rep) m_idle = 0;
      else if (bus.i_tick_1hz && m_idle < TO) m_idle++;
      m_age = chg ? 0 : m_age + 1;
      m_mode = nxt;
      e_blink = int'(m_mode != 0 && ((m_age / BLINK) % 2) == 0);
      m_pm = bus.i_btn_mode;
      m_pi = bus.i_btn_inc;
      m_armed = 1;
    end
  end

  // per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    chk("sec_en", int'(bus.o_sec_en), e_sec);
    chk("min_en", int'(bus.o_min_en), e_min);
    chk("hour_en", int'(bus.o_hour_en), e_hour);
    chk("sec_srst", int'(bus.o_sec_srst), e_srst);
    chk("mode", int'(bus.o_mode), m_mode);
    chk("blink", int'(bus.o_blink), e_blink);
  end

  task automatic drive(bit t, bit m, bit i,
                       bit so = 1'b0, bit mo = 1'b0);
    bus.i_tick_1hz = t;
    bus.i_btn_mode = m;
    bus.i_btn_inc  = i;
    bus.i_sec_ovf  = so;
    bus.i_min_ovf  = mo;
    @(negedge clk);
  endtask

  task automatic all_zero(string nm);
    chk({nm, "_sec"}, int'(bus.o_sec_en), 0);
    chk({nm, "_min"}, int'(bus.o_min_en), 0);
    chk({nm, "_hour"}, int'(bus.o_hour_en), 0);
    chk({nm, "_srst"}, int'(bus.o_sec_srst), 0);
    chk({nm, "_mode"}, int'(bus.o_mode), 0);
    chk({nm, "_blink"}, int'(bus.o_blink), 0);
  endtask

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  int hcnt, mcnt;

  initial begin
    bus.i_tick_1hz = 0; bus.i_btn_mode = 0; bus.i_btn_inc = 0;
    bus.i_sec_ovf = 0; bus.i_min_ovf = 0;
    #1 rst = 1'b1;
    @(negedge clk);
    all_zero("lit_reset");
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0);

    // RUN pass-through
    drive(1, 0, 0);
    chk("lit_run_sec", int'(bus.o_sec_en), 1);
    drive(0, 0, 0, 1, 0);
    chk("lit_run_min", int'(bus.o_min_en), 1);
    chk("lit_run_sec0", int'(bus.o_sec_en), 0);
    drive(0, 0, 0, 0, 1);
    chk("lit_run_hour", int'(bus.o_hour_en), 1);
    chk("lit_run_mode", int'(bus.o_mode), 0);

    // three mode presses
    drive(0, 1, 0);
    chk("lit_press1", int'(bus.o_mode), 1);
    chk("lit_blink_entry", int'(bus.o_blink), 1);
    drive(0, 0, 0);
    drive(0, 1, 0);
    chk("lit_press2", int'(bus.o_mode), 2);
    drive(0, 0, 0);
    drive(0, 1, 0);
    chk("lit_press3", int'(bus.o_mode), 0);
    chk("lit_srst", int'(bus.o_sec_srst), 1);
    drive(0, 0, 0);
    chk("lit_srst_off", int'(bus.o_sec_srst), 0);

    // SET_HOUR with inc held over 4 ticks
    drive(0, 1, 0);
    drive(0, 0, 0);
    hcnt = 0; mcnt = 0;
    drive(0, 0, 1);
    hcnt += int'(bus.o_hour_en); mcnt += int'(bus.o_min_en);
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 1);
      hcnt += int'(bus.o_hour_en); mcnt += int'(bus.o_min_en);
      drive(0, 0, 1);
      hcnt += int'(bus.o_hour_en); mcnt += int'(bus.o_min_en);
    end
    chk("lit_hold_hour_cnt", hcnt, 3);
    chk("lit_hold_min_cnt", mcnt, 0);
    drive(0, 0, 0);

    // simultaneous mode and inc edges
    drive(0, 1, 1);
    chk("lit_both_mode", int'(bus.o_mode), 2);
    chk("lit_both_hour", int'(bus.o_hour_en), 0);
    drive(0, 0, 0);

    // SET_MIN idle timeout, sec_ovf ignored
    mcnt = 0;
    for (int k = 1; k <= 5; k++) begin
      drive(1, 0, 0, 1, 0);
      mcnt += int'(bus.o_min_en);
      if (k < 5) begin
        chk("lit_to_wait", int'(bus.o_mode), 2);
        drive(0, 0, 0, 1, 0);
        mcnt += int'(bus.o_min_en);
      end
    end
    chk("lit_to_mode", int'(bus.o_mode), 0);
    chk("lit_to_srst", int'(bus.o_sec_srst), 0);
    chk("lit_to_min_cnt", mcnt, 0);
    drive(0, 0, 0);

    // async reset mid-set, buttons already high on release
    drive(0, 1, 0);
    drive(0, 0, 0);
    drive(0, 1, 0);
    chk("lit_pre_rst_blink", int'(bus.o_blink), 1);
    chk("lit_pre_rst_mode", int'(bus.o_mode), 2);
    #2;
    rst = 1'b1;
    bus.i_btn_inc = 1'b1;
    bus.i_btn_mode = 1'b1;
    #1;
    all_zero("lit_async_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    hcnt = 0;
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1);
      hcnt += int'(bus.o_hour_en) + int'(bus.o_min_en);
    end
    chk("lit_release_mode", int'(bus.o_mode), 0);
    chk("lit_release_pulse", hcnt, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
